ram_write_arbiter: RTL and testbench
====================================

# ram_write_arbiter

Single-clock write-port controller for the character/tile RAM behind the VGA renderer. It shares the RAM write port between two requesters: A is game logic (cell marks) and B is the cursor/status overlay. Requests use a valid/ready handshake with round-robin arbitration. An optional clear engine sweeps every address with a fill code.

## Interface
- DATA_WIDTH, 7, RAM word width
- ADDR_WIDTH, 9, RAM address width; depth = 2**ADDR_WIDTH
- FILL_CODE, 7'd0, word written by the clear sweep
- CLEAR_ON_RESET, 1, 1 = start a clear sweep on reset release
- clock_i  input  1  sole clock, rising edge
- reset_n_i  input  1  asynchronous, active-low reset
- a_valid_i / b_valid_i  input  1  requester has a write pending
- a_addr_i / b_addr_i  input  ADDR_WIDTH  target address
- a_data_i / b_data_i  input  DATA_WIDTH  write data
- a_ready_o / b_ready_o  output  1  grant; transfer occurs when valid && ready at a clock edge
- clear_req_i  input  1  start a clear sweep (level, sampled each cycle)
- we_o  output  1  to RAM we_i
- write_addr_o  output  ADDR_WIDTH  to RAM write_addr_i
- data_o  output  DATA_WIDTH  to RAM data_i
- clear_busy_o  output  1  sweep in progress
- clear_done_o  output  1  one-cycle pulse after the last sweep write

## Operation
- FSM states: SERVE and CLEAR.
- Reset state is CLEAR with the counter at 0 if CLEAR_ON_RESET=1; otherwise it is SERVE.
- Reset values: we_o=0, write_addr_o=0, data_o=0, clear_done_o=0, last_grant=B.
- clear_busy_o = (state==CLEAR), combinational.
- SERVE:
  - a_ready_o = a_valid_i && !clear_req_i && (!b_valid_i || last_grant==B).
  - b_ready_o is symmetric.
  - Both ready outputs are combinational from the inputs and last_grant. At most one is high.
  - Accepted transfer: on the next edge, register we_o=1 and the winner's addr/data into write_addr_o/data_o, and set last_grant=winner.
  - No transfer: we_o=0. Address and data hold their last values.
- The lone valid requester is always granted, regardless of last_grant.
- clear_req_i high in SERVE: no grant that cycle. Next state is CLEAR with the counter at 0. A pending valid stays pending; requesters must hold valid/addr/data until ready.
- CLEAR:
  - Both ready outputs are 0.
  - Each cycle, register we_o=1, write_addr_o=counter, data_o=FILL_CODE, then increment the counter.
  - The counter is ADDR_WIDTH+1 bits wide, so the terminal count is detected without wrap.
  - After address 2**ADDR_WIDTH-1 is issued, return to SERVE and pulse clear_done_o on the next cycle.
  - clear_req_i is ignored while in CLEAR.
  - last_grant is unchanged by a sweep.
- Reset asserted mid-sweep or mid-write aborts immediately to the reset values. A partial sweep is not resumed; only CLEAR_ON_RESET restarts it.

## Timing
- Grant-to-write latency is 1 cycle: the handshake at edge N produces we_o high during cycle N+1.
- Throughput is one write per cycle.
- Alternating grants under continuous contention: A, B, A, B…
- Sweep length is exactly 2**ADDR_WIDTH cycles of we_o=1 (512 at the defaults).
- clear_done_o is high in the first SERVE cycle after the sweep. Grants are allowed in that same cycle.
- All outputs to the RAM are registered. Only the ready outputs and clear_busy_o are combinational.

## Configuration
- RAM_ARB_CLEAR_EN defined: the CLEAR state, sweep counter, clear_req_i handling and CLEAR_ON_RESET are all compiled in.
- RAM_ARB_CLEAR_EN undefined:
  - The FSM has only SERVE.
  - clear_req_i is ignored and removed from the ready equations.
  - clear_busy_o and clear_done_o are tied to 0; CLEAR_ON_RESET has no effect.
  - Arbitration is unchanged.

## Structure
- Shared package tictactoe_ram_pkg holds:
  - the DATA_WIDTH=7 and ADDR_WIDTH=9 defaults;
  - the FILL_CODE default (blank tile);
  - the state encoding constants SERVE and CLEAR;
  - the requester identifiers A and B.
- One sub-module, ram_clear_sweeper: counter, terminal detect and done pulse. It is instantiated only under RAM_ARB_CLEAR_EN.
- The top level holds the arbitration logic and the output registers.

## Test plan
- Reset with CLEAR_ON_RESET=1, no requests:
  - 512 consecutive we_o cycles with addr 0..511 and data 0;
  - clear_done_o pulses once, then the block is in SERVE with we_o=0.
- A only, valid with addr 9'd4, data 7'd1:
  - a_ready_o is 1 in the same cycle;
  - the next cycle shows we_o=1, write_addr_o=4, data_o=1.
- A and B continuously valid:
  - grants alternate A, B, A, B, with A first after reset;
  - the written addr/data sequence matches each requester's values.
- clear_req_i and a_valid_i high in the same SERVE cycle:
  - a_ready_o=0;
  - the sweep runs for 512 cycles;
  - A's write is issued after the sweep;
  - no RAM address receives A's data before the sweep.
- reset_n_i pulsed low at sweep count 100: outputs go to reset values asynchronously, and the sweep restarts from address 0.
- RAM_ARB_CLEAR_EN undefined, clear_req_i held high: arbitration proceeds normally, and clear_busy_o and clear_done_o stay 0.

Source files
------------

// File: rtl/tictactoe_ram_pkg.sv
// Shared sizing defaults, fill code, FSM encoding and requester identifiers
// for the tile-RAM write path.
package tictactoe_ram_pkg;

   localparam int DATA_WIDTH_DEF = 7;
   localparam int ADDR_WIDTH_DEF = 9;

   // Blank tile code written by the clear sweep.
   localparam logic [DATA_WIDTH_DEF-1:0] FILL_CODE_DEF = 7'd0;

   typedef enum logic { SERVE = 1'b0, CLEAR = 1'b1 } state_e;
   typedef enum logic { REQ_A = 1'b0, REQ_B = 1'b1 } req_e;

endpackage

// File: rtl/ram_clear_sweeper.sv
// Clear-sweep address counter: issues one address per cycle while run_i is high,
// flags the final address and emits a registered done pulse; no backpressure.
`ifdef RAM_ARB_CLEAR_EN
module ram_clear_sweeper
   import tictactoe_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  run_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o,
   output logic                  done_o
);

   logic [ADDR_WIDTH:0] cnt_q, cnt_d, cnt_inc;
   logic                done_q, done_d;

   // The extra MSB lets the terminal address be seen as a carry out of the increment.
   always_comb begin
      cnt_inc = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      last_o  = cnt_inc[ADDR_WIDTH];
      cnt_d   = (run_i && !last_o) ? cnt_inc : '0;
      done_d  = run_i && last_o;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign addr_o = cnt_q[ADDR_WIDTH-1:0];
   assign done_o = done_q;

endmodule
`endif

// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter sharing the tile-RAM write port between A and B; 1-cycle grant-to-write,
// readies drop while clearing. Optional clear sweep compiled in with RAM_ARB_CLEAR_EN.
module ram_write_arbiter
   import tictactoe_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] FILL_CODE      = FILL_CODE_DEF,
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  a_valid_i,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   output logic                  a_ready_o,
   input  logic                  b_valid_i,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   output logic                  b_ready_o,
   input  logic                  clear_req_i,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] write_addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  clear_busy_o,
   output logic                  clear_done_o
);

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   req_e                  last_grant_q, last_grant_d;
   logic                  clear_hold;

`ifdef RAM_ARB_CLEAR_EN
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sweep_addr;
   logic                  sweep_last;
   logic                  sweep_done;

   ram_clear_sweeper #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweeper (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .run_i     (state_q == CLEAR),
      .addr_o    (sweep_addr),
      .last_o    (sweep_last),
      .done_o    (sweep_done)
   );

   assign clear_hold   = (state_q == CLEAR) || clear_req_i;
   assign clear_busy_o = (state_q == CLEAR);
   assign clear_done_o = sweep_done;
`else
   logic unused_cfg;

   assign unused_cfg   = clear_req_i ^ (^FILL_CODE) ^ CLEAR_ON_RESET;
   assign clear_hold   = 1'b0;
   assign clear_busy_o = 1'b0;
   assign clear_done_o = 1'b0;
`endif

   always_comb begin
      a_ready_o    = a_valid_i && !clear_hold && (!b_valid_i || last_grant_q == REQ_B);
      b_ready_o    = b_valid_i && !clear_hold && (!a_valid_i || last_grant_q == REQ_A);
      we_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      last_grant_d = last_grant_q;
      if (a_ready_o) begin
         we_d         = 1'b1;
         addr_d       = a_addr_i;
         data_d       = a_data_i;
         last_grant_d = REQ_A;
      end else if (b_ready_o) begin
         we_d         = 1'b1;
         addr_d       = b_addr_i;
         data_d       = b_data_i;
         last_grant_d = REQ_B;
      end
`ifdef RAM_ARB_CLEAR_EN
      state_d = state_q;
      // Readies are already low in CLEAR, so the sweep simply overrides the write port.
      if (state_q == CLEAR) begin
         we_d   = 1'b1;
         addr_d = sweep_addr;
         data_d = FILL_CODE;
         if (sweep_last) state_d = SERVE;
      end else if (clear_req_i) begin
         state_d = CLEAR;
      end
`endif
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         last_grant_q <= REQ_B;
`ifdef RAM_ARB_CLEAR_EN
         state_q      <= CLEAR_ON_RESET ? CLEAR : SERVE;
`endif
      end else begin
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         last_grant_q <= last_grant_d;
`ifdef RAM_ARB_CLEAR_EN
         state_q      <= state_d;
`endif
      end
   end

   assign we_o         = we_q;
   assign write_addr_o = addr_q;
   assign data_o       = data_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Randomized bench for ram_write_arbiter against a cycle-level reference model
// of the arbitration and clear-sweep rules.
module tb_ram_write_arbiter;

   localparam int AW    = 9;
   localparam int DW    = 7;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] FILL = 7'd0;
`ifdef RAM_ARB_CLEAR_EN
   localparam bit CLR_RST = 1'b1;
   localparam int PC_RAND = 1;
`else
   localparam bit CLR_RST = 1'b0;
   localparam int PC_RAND = 30;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ready, b_ready, we, busy, done;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit            m_clear;
   int            m_idx;
   bit            m_last;   // 0 = A won last, 1 = B won last
   logic          e_we, e_done;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   int            glog[$];

   always #5 clk = ~clk;

   ram_write_arbiter dut (
      .clock_i      (clk),
      .reset_n_i    (rst_n),
      .a_valid_i    (a_valid),
      .a_addr_i     (a_addr),
      .a_data_i     (a_data),
      .a_ready_o    (a_ready),
      .b_valid_i    (b_valid),
      .b_addr_i     (b_addr),
      .b_data_i     (b_data),
      .b_ready_o    (b_ready),
      .clear_req_i  (clear_req),
      .we_o         (we),
      .write_addr_o (waddr),
      .data_o       (wdata),
      .clear_busy_o (busy),
      .clear_done_o (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_we"},   32'(we),    32'(e_we));
      chk({tag, "_addr"}, 32'(waddr), 32'(e_addr));
      chk({tag, "_data"}, 32'(wdata), 32'(e_data));
      chk({tag, "_done"}, 32'(done),  32'(e_done));
   endtask

   task automatic model_reset();
      m_clear = CLR_RST;
      m_idx   = 0;
      m_last  = 1'b1;
      e_we    = 1'b0;
      e_addr  = '0;
      e_data  = '0;
      e_done  = 1'b0;
   endtask

   // Leaves the bench just after a rising edge with reset released.
   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      clear_req = 1'b0;
      model_reset();
      #1;
      check_outs("rst");
      chk("rst_busy", 32'(busy), 32'(CLR_RST));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock: new requests appear with probability pa/pb percent, clear_req with pc percent.
   task automatic step(input int pa, input int pb, input int pc);
      bit ga, gb, blk;
      @(negedge clk);
      if (!a_valid && int'($urandom_range(99)) < pa) begin
         a_valid = 1'b1;
         a_addr  = AW'($urandom);
         a_data  = DW'($urandom);
      end
      if (!b_valid && int'($urandom_range(99)) < pb) begin
         b_valid = 1'b1;
         b_addr  = AW'($urandom);
         b_data  = DW'($urandom);
      end
      clear_req = (int'($urandom_range(99)) < pc);
`ifdef RAM_ARB_CLEAR_EN
      blk = m_clear || clear_req;
`else
      blk = 1'b0;
`endif
      ga = !blk && a_valid && (!b_valid || m_last);
      gb = !blk && b_valid && !ga;
      #1;
      chk("a_rdy", 32'(a_ready), 32'(ga));
      chk("b_rdy", 32'(b_ready), 32'(gb));
      chk("busy",  32'(busy),    32'(m_clear));
      if (a_ready) glog.push_back(0);
      else if (b_ready) glog.push_back(1);
      @(posedge clk);
      #1;
      if (m_clear) begin
         e_we   = 1'b1;
         e_addr = AW'(m_idx);
         e_data = FILL;
         e_done = 1'b0;
         if (m_idx == DEPTH - 1) begin
            m_clear = 1'b0;
            e_done  = 1'b1;
         end else begin
            m_idx++;
         end
      end else begin
         e_done = 1'b0;
         e_we   = ga || gb;
         if (ga) begin
            e_addr  = a_addr;
            e_data  = a_data;
            m_last  = 1'b0;
            a_valid = 1'b0;
         end else if (gb) begin
            e_addr  = b_addr;
            e_data  = b_data;
            m_last  = 1'b1;
            b_valid = 1'b0;
         end
`ifdef RAM_ARB_CLEAR_EN
         if (clear_req) begin
            m_clear = 1'b1;
            m_idx   = 0;
         end
`endif
      end
      check_outs("cyc");
   endtask

   initial begin
      int n_we, n_done, leak, guard;
      model_reset();
      do_reset();

`ifdef RAM_ARB_CLEAR_EN
      // Power-on sweep
      n_we = 0; n_done = 0; guard = 0;
      while (m_clear && guard < 600) begin
         step(0, 0, 0);
         if (we === 1'b1 && wdata === FILL) n_we++;
         if (done === 1'b1) n_done++;
         guard++;
      end
      chk("sweep_len", 32'(n_we), 32'(DEPTH));
      chk("sweep_done_cnt", 32'(n_done), 32'd1);
      step(0, 0, 0);
      chk("post_sweep_we", 32'(we), 32'd0);
      chk("post_sweep_busy", 32'(busy), 32'd0);
`endif

      // Continuous contention: A first, then strict alternation
      glog.delete();
      for (int i = 0; i < 8; i++) step(100, 100, 0);
      chk("alt_len", 32'(glog.size()), 32'd8);
      for (int i = 0; i < glog.size(); i++) chk("alt_seq", 32'(glog[i]), 32'(i % 2));
      repeat (3) step(0, 0, 0);

      // Lone A request
      a_valid = 1'b1; a_addr = 9'd4; a_data = 7'd1;
      step(0, 0, 0);
      chk("aonly_we", 32'(we), 32'd1);
      chk("aonly_addr", 32'(waddr), 32'd4);
      chk("aonly_data", 32'(wdata), 32'd1);

`ifdef RAM_ARB_CLEAR_EN
      // clear_req collides with a pending A write
      a_valid = 1'b1; a_addr = 9'd7; a_data = 7'd5;
      step(0, 0, 100);
      chk("clr_a_rdy", 32'(a_ready), 32'd0);
      leak = 0; n_we = 0; guard = 0;
      while (m_clear && guard < 600) begin
         step(0, 0, 0);
         if (we === 1'b1 && wdata === 7'd5) leak++;
         if (we === 1'b1) n_we++;
         guard++;
      end
      chk("clr_leak", 32'(leak), 32'd0);
      chk("clr_len", 32'(n_we), 32'(DEPTH));
      step(0, 0, 0);
      chk("clr_a_we", 32'(we), 32'd1);
      chk("clr_a_addr", 32'(waddr), 32'd7);
      chk("clr_a_data", 32'(wdata), 32'd5);

      // Reset mid-sweep at count 100
      do_reset();
      guard = 0;
      while (m_idx < 100 && guard < 200) begin
         step(0, 0, 0);
         guard++;
      end
      chk("mid_addr", 32'(waddr), 32'd99);
      #2 rst_n = 1'b0;
      #1;
      chk("async_we", 32'(we), 32'd0);
      chk("async_addr", 32'(waddr), 32'd0);
      chk("async_data", 32'(wdata), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      do_reset();
      step(0, 0, 0);
      chk("restart_we", 32'(we), 32'd1);
      chk("restart_addr", 32'(waddr), 32'd0);
      guard = 0;
      while (m_clear && guard < 600) begin
         step(0, 0, 0);
         guard++;
      end
`else
      // clear_req held high must not disturb arbitration
      for (int i = 0; i < 8; i++) begin
         step(100, 100, 100);
         chk("noclr_busy", 32'(busy), 32'd0);
      end
`endif

      for (int i = 0; i < 3000; i++) step(40, 40, PC_RAND);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
